// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one FSM drives a shared req/ready memory port, an internal GPR file and an ALU.
// Optional MCPU_PERF_CNT_EN adds the cycle_cnt/instret_cnt performance counter ports.
module multicycle_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          NUM_REGS   = 32,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  halt,
  output logic [31:0]           pc_out
`ifdef MCPU_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic        req_en;
  logic [31:0] regs [NUM_REGS];

  // Indices at or above NUM_REGS behave as a hard-wired zero register.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx >> IDX_W) == 5'd0;
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] fn, input logic signed [31:0] x,
                                      input logic signed [31:0] y);
    case (fn)
      F_SUB:   return x - y;
      F_AND:   return x & y;
      F_OR:    return x | y;
      F_SLT:   return (x < y) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic signed [31:0] imm_sext;
  logic               is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
  logic               funct_ok, legal;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_r     = (op == OP_R);
  assign is_addi  = (op == OP_ADDI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT);
  assign legal    = (is_r && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_bne || is_j;

  logic [31:0] rd_a, rd_b;
  logic [31:0] alu_res;
  logic [31:0] br_tgt, jump_tgt;
  logic        br_taken;

  assign rd_a = (rs != 5'd0 && idx_ok(rs)) ? regs[rs[IDX_W-1:0]] : 32'd0;
  assign rd_b = (rt != 5'd0 && idx_ok(rt)) ? regs[rt[IDX_W-1:0]] : 32'd0;

  // lw/sw reuse the adder path, so alu_res is also the effective address.
  assign alu_res  = alu(is_r ? funct : F_ADD, a, is_r ? b : imm_sext);
  assign br_taken = is_beq ? (a == b) : (a != b);
  assign br_tgt   = pc + {imm_sext[29:0], 2'b00};
  assign jump_tgt = {pc[31:28], ir[25:0], 2'b00};

  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        wb_en;

  assign wb_idx  = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr : alu_out;
  assign wb_en   = (state == S_WB) && (wb_idx != 5'd0) && idx_ok(wb_idx);

  logic [31:0] addr_int;

  // req_en keeps the port idle for the first cycle out of reset.
  assign mem_req   = req_en && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = mem_req && (state == S_MEM) && is_sw;
  assign addr_int  = (state == S_MEM) ? alu_out : pc;
  assign mem_addr  = mem_req ? addr_int[ADDR_WIDTH-1:0] : '0;
  assign mem_wdata = mem_we ? b : 32'd0;
  assign halt      = (state == S_HALT);
  assign pc_out    = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_req && mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw || is_sw)        state_nxt = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
        else if (is_r || is_addi)  state_nxt = S_WB;
        else                       state_nxt = S_FETCH;
      end
      S_MEM:    if (mem_req && mem_ready) state_nxt = is_lw ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      req_en  <= 1'b0;
    end else begin
      req_en <= 1'b1;
      case (state)
        S_FETCH: begin
          if (mem_req && mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= rd_a;
          b <= rd_b;
        end
        S_EXEC: begin
          if (is_r || is_addi || is_lw || is_sw) alu_out <= alu_res;
          else if (is_j)                         pc      <= jump_tgt;
          else if (br_taken)                     pc      <= br_tgt;
        end
        S_MEM: begin
          if (mem_req && mem_ready && is_lw) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (wb_en) begin
      regs[wb_idx[IDX_W-1:0]] <= wb_data;
    end
  end

`ifdef MCPU_PERF_CNT_EN
  logic retire;

  assign retire = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) &&
                  (state_nxt == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_HALT) cycle_cnt   <= cycle_cnt + 32'd1;
      if (retire)          instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a wait-state memory model plus a linear sequence of hand-checked programs.
module tb_multicycle_cpu;

  localparam logic [31:0] RPC = 32'h3000_0000;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halt;
  logic [31:0] pc_out;
`ifdef MCPU_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_cpu #(.RESET_PC(RPC), .NUM_REGS(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .halt       (halt),
    .pc_out     (pc_out)
`ifdef MCPU_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  int n_tests;
  int n_fail;
  int cyc;
  int waits;
  logic hold;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [31:0] acc_addr [0:31];
  int          acc_cyc [0:31];
  int          acc_n;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_n;
  int          unstable;
  int          misalign;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Memory responder: addresses with top nibble 3 hit the program store, others the data store.
  initial begin
    int          wcnt;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    wcnt = 0; cap_addr = 0; cap_wdata = 0; cap_we = 0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    acc_n = 0; wr_n = 0; unstable = 0; misalign = 0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'hDEAD_0000 | i;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ready = 1'b0; wcnt = 0; acc_n = 0; wr_n = 0;
      end else if (mem_req) begin
        if (wcnt == 0) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        end else if (cap_addr !== mem_addr || cap_we !== mem_we || cap_wdata !== mem_wdata) begin
          unstable = unstable + 1;
        end
        if (mem_addr[1:0] != 2'b00) misalign = misalign + 1;
        if (!hold && wcnt >= waits) begin
          mem_ready = 1'b1;
          mem_rdata = (mem_addr[31:28] == 4'h3) ? imem[mem_addr[9:2]] : dmem[mem_addr[9:2]];
          if (mem_we) begin
            dmem[mem_addr[9:2]] = mem_wdata;
            if (wr_n < 16) begin
              wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
          end
          if (acc_n < 32) begin
            acc_addr[acc_n] = mem_addr; acc_cyc[acc_n] = cyc;
          end
          acc_n = acc_n + 1;
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          wcnt = wcnt + 1;
        end
      end else begin
        mem_ready = 1'b0; wcnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = ILL;
  endtask

  task automatic run_until_halt(input string tag, input int max);
    for (int i = 0; i < max && !halt; i++) tick();
    check(tag, halt, 1'b1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; waits = 0; hold = 1'b0;

    // Test 1: addi/addi/add, reset state, 4-cycle R/addi latency
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'hFFF9);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0200);
    do_reset();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_halt", halt, 1'b0);
    check("rst_pc", pc_out, RPC);
`ifdef MCPU_PERF_CNT_EN
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_instret_cnt", instret_cnt, 32'd0);
`endif
    tick();
    check("t1_first_req", mem_req, 1'b1);
    check("t1_first_addr", mem_addr, RPC);
    repeat (12) tick();
    check("t1_pc_after_12", pc_out, RPC + 32'hC);
    check("t1_fetch4_addr", mem_addr, RPC + 32'hC);
`ifdef MCPU_PERF_CNT_EN
    check("t1_instret", instret_cnt, 32'd3);
    check("t1_cycles", cycle_cnt, 32'd13);
`endif
    run_until_halt("t1_halt", 40);
    check("t1_wr_n", wr_n, 1);
    check("t1_wr_addr", wr_addr[0], 32'h200);
    check("t1_r3", wr_data[0], 32'h3);
    check("t1_halt_pc", pc_out, RPC + 32'h14);

    // Test 2: sw/lw through 3 wait states
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
    imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0204);
    waits = 3;
    do_reset();
    run_until_halt("t2_halt", 200);
    check("t2_wr_n", wr_n, 2);
    check("t2_sw_addr", wr_addr[0], 32'h8);
    check("t2_sw_data", wr_data[0], 32'h5);
    check("t2_r4_addr", wr_addr[1], 32'h204);
    check("t2_r4", wr_data[1], 32'h5);
    check("t2_lw_addr", acc_addr[4], 32'h8);
    check("t2_stable", unstable, 0);
    check("t2_addi_lat", acc_cyc[1] - acc_cyc[0], 7);
    check("t2_lw_lat", acc_cyc[5] - acc_cyc[3], 11);
    waits = 0;

    // ALU functions: sub/and/or/slt signed, then an illegal funct
    clear_prog();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd6);
    imem[2]  = enc_r(5'd2, 5'd1, 5'd3, 6'h22);
    imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h24);
    imem[4]  = enc_r(5'd1, 5'd2, 5'd5, 6'h25);
    imem[5]  = enc_r(5'd1, 5'd2, 5'd6, 6'h2A);
    imem[6]  = enc_r(5'd2, 5'd1, 5'd7, 6'h2A);
    imem[7]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0300);
    imem[8]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0304);
    imem[9]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0308);
    imem[10] = enc_i(6'h2B, 5'd0, 5'd6, 16'h030C);
    imem[11] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0310);
    imem[12] = enc_r(5'd0, 5'd0, 5'd0, 6'h21);
    do_reset();
    run_until_halt("alu_halt", 100);
    check("alu_sub", wr_data[0], 32'd9);
    check("alu_and", wr_data[1], 32'd4);
    check("alu_or", wr_data[2], 32'hFFFF_FFFF);
    check("alu_slt_true", wr_data[3], 32'd1);
    check("alu_slt_false", wr_data[4], 32'd0);
    check("alu_ill_funct_pc", pc_out, RPC + 32'h34);

    // Test 3: bne not taken, j across regions, beq taken to itself
    clear_prog();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1]  = enc_i(6'h05, 5'd1, 5'd1, 16'd5);
    imem[2]  = enc_j(26'h40);
    imem[64] = enc_j(26'h4);
    imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    for (int i = 0; i < 60 && acc_n < 6; i++) tick();
    check("t3_acc_count", acc_n >= 6, 1'b1);
    check("t3_bne_next", acc_addr[2], RPC + 32'h8);
    check("t3_j_tgt", acc_addr[3], 32'h3000_0100);
    check("t3_j_back", acc_addr[4], RPC + 32'h10);
    check("t3_beq_taken", acc_addr[5], RPC + 32'h10);
    check("t3_bne_lat", acc_cyc[2] - acc_cyc[1], 3);
    check("t3_beq_lat", acc_cyc[5] - acc_cyc[4], 3);
    check("t3_no_halt", halt, 1'b0);

    // Test 4: illegal opcode, halt timing and recovery via rst
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    do_reset();
    tick();
    repeat (4) tick();
    check("t4_fetch_ill_addr", mem_addr, RPC + 32'h4);
    tick();
    check("t4_decode_halt", halt, 1'b0);
    check("t4_decode_req", mem_req, 1'b0);
    tick();
    check("t4_halt", halt, 1'b1);
    check("t4_halt_pc", pc_out, RPC + 32'h8);
    repeat (4) tick();
    check("t4_halt_req", mem_req, 1'b0);
    check("t4_halt_hold", halt, 1'b1);
    check("t4_pc_frozen", pc_out, RPC + 32'h8);
    do_reset();
    check("t4_rst_clears", halt, 1'b0);
    tick();
    check("t4_refetch", mem_addr, RPC);

    // Test 5: R0 stays zero, sw/lw latency, misaligned lw halts without a request
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0210);
    imem[2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0210);
    imem[3] = enc_i(6'h23, 5'd0, 5'd5, 16'h0001);
    do_reset();
    run_until_halt("t5_halt", 60);
    check("t5_r0", wr_data[0], 32'd0);
    check("t5_sw_addr", wr_addr[0], 32'h210);
    check("t5_sw_lat", acc_cyc[3] - acc_cyc[1], 4);
    check("t5_lw_lat", acc_cyc[5] - acc_cyc[3], 5);
    check("t5_halt_pc", pc_out, RPC + 32'h10);
    repeat (5) tick();
    check("t5_no_access", acc_n, 6);
    check("t5_req_low", mem_req, 1'b0);

    // Test 6: reset while a store is stalled in MEM
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0220);
    do_reset();
    tick();
    repeat (7) tick();
    hold = 1'b1;
    check("t6_mem_req", mem_req, 1'b1);
    check("t6_mem_we", mem_we, 1'b1);
    check("t6_mem_addr", mem_addr, 32'h220);
    check("t6_mem_wdata", mem_wdata, 32'd5);
    repeat (3) tick();
    check("t6_wait_addr", mem_addr, 32'h220);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = 1'b0;
    check("t6_req_after_rst", mem_req, 1'b0);
    check("t6_pc_after_rst", pc_out, RPC);
    check("t6_no_store", dmem[8'h88], 32'hDEAD_0088);
`ifdef MCPU_PERF_CNT_EN
    check("t6_cycle_cnt", cycle_cnt, 32'd0);
    check("t6_instret_cnt", instret_cnt, 32'd0);
`endif
    tick();
    check("t6_refetch_req", mem_req, 1'b1);
    check("t6_refetch_addr", mem_addr, RPC);
    check("t6_refetch_we", mem_we, 1'b0);
    check("no_misaligned_req", misalign, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
